// File: rtl/game_level_sequencer.sv
// Level sequencer for the game: walks levels 1..MAX_LEVEL, derives goal and time budget,
// and handles lives, pause/resume and the won/over outcomes.
module game_level_sequencer #(
   parameter int MAX_LEVEL       = 5,
   parameter int LEVEL_W         = 3,
   parameter int SCORE_W         = 14,
   parameter int TIME_W          = 8,
   parameter int INIT_GOAL       = 200,
   parameter int GOAL_DT         = 10,
   parameter int INIT_TIME       = 60,
   parameter int TIME_DT         = 5,
   parameter int MIN_TIME        = 20,
   parameter int LIVES           = 3,
   parameter int START_PULSE_LEN = 3
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic [SCORE_W-1:0] score,
   input  logic               next_level,
   input  logic               skip_level,
   input  logic               pause_req,
   input  logic               level_ended,
   output logic               start_level,
   output logic [LEVEL_W-1:0] level_num,
   output logic [SCORE_W-1:0] goal,
   output logic [TIME_W-1:0]  timer_time,
   output logic [2:0]         lives_left,
   output logic               paused,
   output logic               level_passed,
   output logic               game_over,
   output logic               game_won
);

   localparam int CNT_W = (START_PULSE_LEN > 1) ? $clog2(START_PULSE_LEN) : 1;
   localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(START_PULSE_LEN - 1);
   localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(MAX_LEVEL);
   localparam logic [LEVEL_W-1:0] LEVEL_ONE  = LEVEL_W'(1);
   localparam logic [2:0]         LIVES_INIT = 3'(LIVES);

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_START,
      S_PLAY,
      S_PAUSE,
      S_EVAL,
      S_WAIT_NEXT,
      S_RETRY,
      S_GAME_WON,
      S_GAME_OVER
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   counter;
   logic [LEVEL_W-1:0] target_level;
   logic               next_prev;
   logic               skip_prev;
   logic               pause_prev;
   logic               next_pulse;
   logic               skip_pulse;
   logic               pause_pulse;

   assign next_pulse  = next_level & ~next_prev;
   assign skip_pulse  = skip_level & ~skip_prev;
   assign pause_pulse = pause_req  & ~pause_prev;

   // Wide intermediate arithmetic so large parameters saturate instead of wrapping.
   function automatic logic [SCORE_W-1:0] goal_of(input logic [LEVEL_W-1:0] lvl);
      logic [47:0] steps;
      logic [47:0] sum;
      steps = (lvl == '0) ? 48'd0 : (48'(lvl) - 48'd1);
      sum   = 48'(INIT_GOAL) + 48'(GOAL_DT) * steps;
      if (sum > 48'({SCORE_W{1'b1}}))
         goal_of = '1;
      else
         goal_of = SCORE_W'(sum);
   endfunction

   function automatic logic [TIME_W-1:0] time_of(input logic [LEVEL_W-1:0] lvl);
      logic [47:0] steps;
      logic [47:0] dec;
      logic [47:0] t;
      steps = (lvl == '0) ? 48'd0 : (48'(lvl) - 48'd1);
      dec   = 48'(TIME_DT) * steps;
      if ((dec >= 48'(INIT_TIME)) || ((48'(INIT_TIME) - dec) < 48'(MIN_TIME)))
         t = 48'(MIN_TIME);
      else
         t = 48'(INIT_TIME) - dec;
      if (t > 48'({TIME_W{1'b1}}))
         time_of = '1;
      else
         time_of = TIME_W'(t);
   endfunction

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state        <= S_IDLE;
         counter      <= '0;
         target_level <= '0;
         next_prev    <= 1'b0;
         skip_prev    <= 1'b0;
         pause_prev   <= 1'b0;
         start_level  <= 1'b0;
         level_num    <= '0;
         goal         <= '0;
         timer_time   <= '0;
         lives_left   <= '0;
         paused       <= 1'b0;
         level_passed <= 1'b0;
         game_over    <= 1'b0;
         game_won     <= 1'b0;
      end else begin
         next_prev  <= next_level;
         skip_prev  <= skip_level;
         pause_prev <= pause_req;

         case (state)
            S_IDLE: begin
               if (next_pulse) begin
                  target_level <= LEVEL_ONE;
                  lives_left   <= LIVES_INIT;
                  state        <= S_INIT;
               end
            end

            S_INIT: begin
               level_num   <= target_level;
               goal        <= goal_of(target_level);
               timer_time  <= time_of(target_level);
               counter     <= CNT_LOAD;
               start_level <= 1'b1;
               state       <= S_START;
            end

            S_START: begin
               if (counter == '0) begin
                  start_level <= 1'b0;
                  state       <= S_PLAY;
               end else begin
                  counter <= counter - 1'b1;
               end
            end

            // A skip at the last level falls through to the lower-priority checks.
            S_PLAY: begin
               if (skip_pulse && (level_num < LAST_LEVEL)) begin
                  target_level <= level_num + LEVEL_ONE;
                  state        <= S_INIT;
               end else if (level_ended) begin
                  state <= S_EVAL;
               end else if (pause_pulse) begin
                  paused <= 1'b1;
                  state  <= S_PAUSE;
               end
            end

            S_PAUSE: begin
               if (pause_pulse) begin
                  paused <= 1'b0;
                  state  <= S_PLAY;
               end
            end

            S_EVAL: begin
               if (score >= goal) begin
                  if (level_num < LAST_LEVEL) begin
                     level_passed <= 1'b1;
                     state        <= S_WAIT_NEXT;
                  end else begin
                     game_won <= 1'b1;
                     state    <= S_GAME_WON;
                  end
               end else if (lives_left > 3'd1) begin
                  lives_left <= lives_left - 3'd1;
                  state      <= S_RETRY;
               end else begin
                  lives_left <= '0;
                  game_over  <= 1'b1;
                  state      <= S_GAME_OVER;
               end
            end

            S_WAIT_NEXT: begin
               if (next_pulse) begin
                  level_passed <= 1'b0;
                  target_level <= level_num + LEVEL_ONE;
                  state        <= S_INIT;
               end
            end

            S_RETRY: begin
               if (next_pulse) begin
                  target_level <= level_num;
                  state        <= S_INIT;
               end
            end

            S_GAME_WON, S_GAME_OVER: begin
               if (next_pulse) begin
                  level_num    <= '0;
                  goal         <= '0;
                  timer_time   <= '0;
                  lives_left   <= '0;
                  paused       <= 1'b0;
                  level_passed <= 1'b0;
                  game_over    <= 1'b0;
                  game_won     <= 1'b0;
                  state        <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
